// File: rtl/secuenciador_filtro.sv
// secuenciador_filtro: time-multiplexed FIR filter sequencer.
// One shared external multiplier (1-cycle latency) and an external
// coefficient ROM are walked tap by tap. The accumulator saturates on every
// addition, and a sticky bit records whether any saturation happened.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; delay line, y_out and sat_flag are held
// MAC   | presenting tap idx to the multiplier, accumulating tap idx-1
// DRAIN | accumulating the last product and loading y_out / sat_flag
module secuenciador_filtro #(
  parameter int N    = 25,
  parameter int TAPS = 8,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  x_in,
  output logic [AW-1:0] coef_addr,
  input  logic [N-1:0]  coef_data,
  output logic [N-1:0]  mult_a,
  output logic [N-1:0]  mult_b,
  input  logic [N-1:0]  mult_trunc,
  output logic [N-1:0]  y_out,
  output logic          y_valid,
  output logic          sat_flag,
  output logic          busy,
  output logic          overrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MAC   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
  localparam logic [N-1:0]  POS_MAX  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  NEG_MIN  = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    state;
  logic [AW-1:0] idx;
  logic [N-1:0]  acc;
  logic          sticky;
  logic [N-1:0]  dline [TAPS];

  logic [N-1:0]  tap_sel;
  logic [N-1:0]  sum_raw;
  logic [N-1:0]  sum_val;
  logic          sum_ovf;
  logic          accept;
  logic          acc_en;

  assign busy   = (state != IDLE);
  assign accept = (state == IDLE) && start;
  // The product for tap 0 only appears after the first MAC edge, so the
  // first MAC edge must not accumulate.
  assign acc_en = (state == MAC) && (idx != '0);

  // Select the delay-line word for the current tap without indexing the
  // array by a wider-than-needed address.
  always_comb begin
    tap_sel = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (idx == AW'(k)) tap_sel = dline[k];
    end
  end

  // Signed saturating add of the accumulator and the returning product.
  always_comb begin
    sum_raw = acc + mult_trunc;
    sum_ovf = (acc[N-1] == mult_trunc[N-1]) && (sum_raw[N-1] != acc[N-1]);
    if (sum_ovf) sum_val = acc[N-1] ? NEG_MIN : POS_MAX;
    else         sum_val = sum_raw;
  end

  // Multiplier operands and ROM address are only live during MAC.
  always_comb begin
    coef_addr = '0;
    mult_a    = '0;
    mult_b    = '0;
    if (state == MAC) begin
      coef_addr = idx;
      mult_a    = tap_sel;
      mult_b    = coef_data;
    end
  end

  // Sequencer: state and tap index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) state <= DRAIN;
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Delay line shifts only when a new sample is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) dline[k] <= '0;
    end else if (accept) begin
      for (int k = TAPS - 1; k > 0; k--) dline[k] <= dline[k-1];
      dline[0] <= x_in;
    end
  end

  // Accumulator and sticky saturation bit, both restarted per sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (accept) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (acc_en || (state == DRAIN)) begin
      acc    <= sum_val;
      sticky <= sticky | sum_ovf;
    end
  end

  // Result registers and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_out    <= '0;
      sat_flag <= 1'b0;
      y_valid  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      overrun <= start && (state != IDLE);
      if (state == DRAIN) begin
        y_out    <= sum_val;
        sat_flag <= sticky | sum_ovf;
        y_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_secuenciador_filtro.sv
// Bench for secuenciador_filtro: external multiplier and coefficient ROM
// models, directed samples with hand-computed results, and a scoreboard
// monitor that checks every y_valid pulse and the held outputs in between.
module tb_secuenciador_filtro;
  localparam int N    = 25;
  localparam int TAPS = 8;
  localparam int AW   = 5;

  localparam logic [N-1:0] ONE  = 25'h0004000;
  localparam logic [N-1:0] PMAX = 25'h0FFFFFF;
  localparam logic [N-1:0] NMIN = 25'h1000000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N-1:0]  x_in;
  logic [AW-1:0] coef_addr;
  logic [N-1:0]  coef_data;
  logic [N-1:0]  mult_a;
  logic [N-1:0]  mult_b;
  logic [N-1:0]  mult_trunc = '0;
  logic [N-1:0]  y_out;
  logic          y_valid;
  logic          sat_flag;
  logic          busy;
  logic          overrun;

  typedef struct {
    logic [N-1:0] y;
    logic         s;
  } exp_t;

  exp_t         sb [$];
  logic [N-1:0] coef_rom [32];
  logic [N-1:0] hold_y = '0;
  logic         hold_s = 1'b0;
  bit           mon_en = 1'b0;
  int           total = 0;
  int           bad = 0;

  secuenciador_filtro #(.N(N), .TAPS(TAPS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in),
    .coef_addr(coef_addr), .coef_data(coef_data),
    .mult_a(mult_a), .mult_b(mult_b), .mult_trunc(mult_trunc),
    .y_out(y_out), .y_valid(y_valid), .sat_flag(sat_flag),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  assign coef_data = coef_rom[coef_addr];

  function automatic logic [N-1:0] mul_model(logic [N-1:0] a, logic [N-1:0] b);
    longint pa, pb, pr;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    pr = (pa * pb) >>> 14;
    if (pr > 64'sd16777215)       return PMAX;
    else if (pr < -64'sd16777216) return NMIN;
    else                          return pr[N-1:0];
  endfunction

  always @(posedge clk) mult_trunc <= mul_model(mult_a, mult_b);

  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check1(string name, logic act, logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops expectations on each y_valid, otherwise checks hold.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (y_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_y_valid: got y=%h want no pulse at %0t", y_out, $time);
        end else begin
          e = sb.pop_front();
          check("y_out", y_out, e.y);
          check1("sat_flag", sat_flag, e.s);
          hold_y = e.y;
          hold_s = e.s;
        end
      end else begin
        check("y_hold", y_out, hold_y);
        check1("sat_hold", sat_flag, hold_s);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(logic [N-1:0] ey, logic es);
    exp_t e;
    e.y = ey;
    e.s = es;
    sb.push_back(e);
  endtask

  // One accepted sample, 12-cycle spacing.
  task automatic send(logic [N-1:0] x, logic [N-1:0] ey, logic es);
    start = 1'b1;
    x_in  = x;
    expect_result(ey, es);
    step();
    start = 1'b0;
    x_in  = '0;
    repeat (11) step();
  endtask

  task automatic set_coefs_unity();
    for (int k = 0; k < 32; k++) coef_rom[k] = ONE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_coefs_unity();
    reset = 1'b1;
    start = 1'b0;
    x_in  = '0;
    repeat (3) step();
    reset = 1'b0;
    mon_en = 1'b1;

    check("rst_y_out", y_out, '0);
    check1("rst_sat", sat_flag, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_y_valid", y_valid, 1'b0);
    check1("rst_overrun", overrun, 1'b0);
    check("rst_mult_a", mult_a, '0);
    check("rst_mult_b", mult_b, '0);
    check("rst_coef_addr", N'(coef_addr), '0);

    // Impulse, first sample with cycle-by-cycle latency checks.
    start = 1'b1;
    x_in  = ONE;
    expect_result(ONE, 1'b0);
    step();
    start = 1'b0;
    x_in  = '0;
    for (int i = 0; i <= 10; i++) begin
      check1("lat_busy", busy, i <= 8);
      check1("lat_y_valid", y_valid, i == 9);
      check("lat_coef_addr", N'(coef_addr), (i <= 7) ? N'(i) : '0);
      check("lat_mult_a", mult_a, (i == 0) ? ONE : '0);
      check("lat_mult_b", mult_b, (i <= 7) ? ONE : '0);
      if (i < 10) step();
    end
    step();
    for (int k = 2; k <= 8; k++) send('0, ONE, 1'b0);
    send('0, '0, 1'b0);

    // Positive saturation, then flush.
    for (int k = 1; k <= 8; k++) send(PMAX, PMAX, k >= 2);
    for (int k = 1; k <= 8; k++) send('0, (k <= 7) ? PMAX : '0, k <= 6);

    // Negative saturation, then flush.
    for (int k = 1; k <= 8; k++) send(NMIN, NMIN, k >= 2);
    for (int k = 1; k <= 8; k++) send('0, (k <= 7) ? NMIN : '0, k <= 6);

    // Overrun: extra start sampled at edge 3 of an operation.
    start = 1'b1;
    x_in  = 25'h0000100;
    expect_result(25'h0000100, 1'b0);
    step();
    start = 1'b0;
    x_in  = '0;
    step();
    step();
    start = 1'b1;
    x_in  = 25'h0007777;
    step();
    check1("ovr_pulse", overrun, 1'b1);
    check1("ovr_busy", busy, 1'b1);
    start = 1'b0;
    x_in  = '0;
    step();
    check1("ovr_clear", overrun, 1'b0);
    repeat (8) step();
    send(25'h0000200, 25'h0000300, 1'b0);

    // Weighted taps: coef[k] = k+1.
    for (int k = 0; k < TAPS; k++) coef_rom[k] = N'((k + 1) * 16384);
    send(25'h0000040, 25'h0000740, 1'b0);
    send('0, 25'h0000A80, 1'b0);
    set_coefs_unity();

    // Reset at edge 4 of an operation: no result, everything cleared.
    start = 1'b1;
    x_in  = 25'h0000555;
    step();
    start = 1'b0;
    x_in  = '0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset  = 1'b0;
    hold_y = '0;
    hold_s = 1'b0;
    check("mid_rst_y_out", y_out, '0);
    check1("mid_rst_sat", sat_flag, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_y_valid", y_valid, 1'b0);
    check1("mid_rst_overrun", overrun, 1'b0);
    check("mid_rst_mult_a", mult_a, '0);
    check("mid_rst_coef_addr", N'(coef_addr), '0);
    repeat (12) step();
    send(ONE, ONE, 1'b0);
    for (int k = 2; k <= 8; k++) send('0, ONE, 1'b0);
    send('0, '0, 1'b0);

    // Start in the same cycle as y_valid is accepted.
    begin
      int n;
      start = 1'b1;
      x_in  = 25'h0000100;
      expect_result(25'h0000100, 1'b0);
      step();
      start = 1'b0;
      x_in  = '0;
      n = 0;
      while (!y_valid && n < 20) begin
        step();
        n++;
      end
      check1("b2b_y_valid_seen", y_valid, 1'b1);
      start = 1'b1;
      x_in  = 25'h0000080;
      expect_result(25'h0000180, 1'b0);
      step();
      check1("b2b_no_overrun", overrun, 1'b0);
      check1("b2b_busy", busy, 1'b1);
      start = 1'b0;
      x_in  = '0;
      repeat (11) step();
    end

    repeat (3) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
